des_align_ctrl: RTL
===================

DES_ALIGN_CTRL -- requirements
Module: des_align_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 3, giving the deserializer tree depth; word width W = 2**STAGES.
REQ-002 SHALL have parameter MARKER [W-1:0], default 8'hE4, giving the training word; it SHALL be non-periodic under rotation.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, giving the consecutive marker matches required for lock (range 1..15).
REQ-004 SHALL have parameter TIMEOUT, default 64, giving the unmatched valid words in SEARCH before search_timeout is flagged.
REQ-005 SHALL have port clk, input, 1 bit: the slow (divided) deserializer word clock; the single clock of the block.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a new deserialized word.
REQ-008 SHALL have port in_data, input, W bits: raw word; bit 0 is the earliest received bit.
REQ-009 SHALL have port realign, input, 1 bit: synchronous pulse forcing a new search.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds an aligned word.
REQ-011 SHALL have port out_data, output, W bits: aligned word.
REQ-012 SHALL have port locked, output, 1 bit: alignment established.
REQ-013 SHALL have port shift, output, clog2(W) bits: current alignment offset.
REQ-014 SHALL have port search_timeout, output, 1 bit: sticky no-match flag.

Function
REQ-015 SHALL keep a prev register (W bits), loaded with in_data on every in_valid cycle; define concat = {in_data, prev} (2W bits) and candidate(s) = concat[s +: W] for s in 0..W-1.
REQ-016 SHALL implement states SEARCH, VERIFY and LOCKED, entering SEARCH on reset.
REQ-017 In SEARCH, on in_valid, SHALL test all W candidates against MARKER; the lowest matching s is captured into shift, match count set to 1, next state VERIFY (LOCKED directly if LOCK_COUNT == 1).
REQ-018 In VERIFY, on in_valid, SHALL compare candidate(shift) only: a match increments the count and enters LOCKED when count reaches LOCK_COUNT; a mismatch returns to SEARCH with the count cleared and shift held.
REQ-019 In LOCKED, on each in_valid, SHALL register out_data = candidate(shift) and assert out_valid for exactly one cycle (latency 1 clk); LOCKED SHALL persist until realign or reset.
REQ-020 Cycles with in_valid low SHALL not change state, counts, prev or shift; out_valid SHALL be 0 in them.
REQ-021 In SEARCH, each in_valid word with no match SHALL increment a saturating counter; search_timeout SHALL assert when the counter reaches TIMEOUT and stay high until SEARCH is left, realign, or reset.
REQ-022 realign SHALL move to SEARCH on the next edge from any state, clearing counts, locked, out_valid and search_timeout; realign SHALL win over a simultaneous in_valid (that word updates prev only).
REQ-023 locked SHALL be 1 exactly in LOCKED; shift SHALL be driven from the captured register at all times.

Reset
REQ-024 On rst, SHALL asynchronously clear state to SEARCH, prev, shift, all counters, out_data, out_valid, locked and search_timeout to 0.
REQ-025 Assertion of rst mid-lock SHALL drop locked and out_valid immediately, without waiting for a clk edge.

Structure
REQ-026 SHALL place the state enum, W, and the shift-width localparam in the shared des_pkg package.
REQ-027 SHALL use one combinational sub-module, bit_aligner (concat, s -> candidate), instantiated W times for the search and once for the data path.

Verification
REQ-028 SHALL cover: a repeated MARKER stream offset by 3 bits -> locked rises after 4 valid words, shift = 3, out_data = 8'hE4 every valid cycle thereafter.
REQ-029 SHALL cover: 3 matching words then one corrupted word -> return to SEARCH, locked = 0; relock after 4 further clean words.
REQ-030 SHALL cover: 64 valid all-zero words -> search_timeout = 1 on the cycle after the 64th; a following clean marker stream clears it on leaving SEARCH.
REQ-031 SHALL cover: realign while LOCKED with in_valid = 1 in the same cycle -> SEARCH next cycle, out_valid = 0, locked = 0.
REQ-032 SHALL cover: in_valid gaps (1 of every 3 cycles) during VERIFY -> lock after 4 valid words, not after 4 cycles.
REQ-033 SHALL cover: rst asserted mid-LOCKED between clk edges -> locked = 0, out_valid = 0 immediately; SEARCH after release.

Source files
------------

// File: rtl/des_pkg.sv
// Shared definitions for the deserializer word-alignment controller.
//   state_e      : alignment FSM states
//   STAGES_DEF   : default deserializer tree depth
//   W, SHIFT_W   : word width and alignment-offset width for the default depth
//   shift_width  : offset width for an arbitrary word width (at least 1 bit)
package des_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int STAGES_DEF = 3;
  localparam int W          = 2 ** STAGES_DEF;
  localparam int SHIFT_W    = $clog2(W);

  function automatic int shift_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_aligner.sv
// Combinational barrel selector: picks the W-bit window starting at bit s of
// a 2W-bit concatenation {current word, previous word}.
//   concat : input  2W bits, bit 0 is the earliest received bit
//   s      : input  window start offset
//   cand   : output selected W-bit candidate word
module bit_aligner
  import des_pkg::*;
#(
  parameter int WD  = W,
  parameter int SWD = shift_width(WD)
) (
  input  logic [2*WD-1:0] concat,
  input  logic [SWD-1:0]  s,
  output logic [WD-1:0]   cand
);

  assign cand = concat[s +: WD];

endmodule

// File: rtl/des_align_ctrl.sv
// Word-alignment controller for a 1:W deserializer. Searches the two most
// recent words for a training marker at every bit offset, verifies the found
// offset over LOCK_COUNT consecutive words, then streams aligned words.
//   clk            : input  word clock
//   rst            : input  asynchronous active-high reset
//   in_valid       : input  in_data holds a new word
//   in_data        : input  raw word, bit 0 received first
//   realign        : input  pulse forcing a fresh search
//   out_valid      : output out_data holds an aligned word (one cycle)
//   out_data       : output aligned word
//   locked         : output alignment established
//   shift          : output current alignment offset
//   search_timeout : output sticky flag, too many unmatched words while searching
module des_align_ctrl
  import des_pkg::*;
#(
  parameter int                    STAGES     = STAGES_DEF,
  parameter logic [2**STAGES-1:0]  MARKER     = 8'hE4,
  parameter int                    LOCK_COUNT = 4,
  parameter int                    TIMEOUT    = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [2**STAGES-1:0]                in_data,
  input  logic                                realign,
  output logic                                out_valid,
  output logic [2**STAGES-1:0]                out_data,
  output logic                                locked,
  output logic [shift_width(2**STAGES)-1:0]   shift,
  output logic                                search_timeout
);

  localparam int WL  = 2 ** STAGES;
  localparam int SWL = shift_width(WL);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [3:0]    LCNT   = 4'(LOCK_COUNT);

  state_e          state_q, state_d;
  logic [WL-1:0]   prev_q, prev_d;
  logic [SWL-1:0]  shift_q, shift_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   miss_q, miss_d;
  logic            timeout_q, timeout_d;
  logic            out_valid_q, out_valid_d;
  logic [WL-1:0]   out_data_q, out_data_d;
  logic            locked_q;

  logic [2*WL-1:0] concat;
  logic [WL-1:0]   cand [WL];
  logic [WL-1:0]   cand_sel;
  logic [WL-1:0]   hit;
  logic [SWL-1:0]  first_s;

  assign concat = {in_data, prev_q};

  // One selector per offset for the parallel search.
  for (genvar g = 0; g < WL; g++) begin : g_search
    bit_aligner #(.WD(WL), .SWD(SWL)) u_search (
      .concat (concat),
      .s      (SWL'(g)),
      .cand   (cand[g])
    );
    assign hit[g] = (cand[g] == MARKER);
  end

  // Data-path selector at the captured offset.
  bit_aligner #(.WD(WL), .SWD(SWL)) u_data (
    .concat (concat),
    .s      (shift_q),
    .cand   (cand_sel)
  );

  // Lowest matching offset wins: scan downward so the last hit written is the lowest.
  always_comb begin
    first_s = '0;
    for (int s = WL - 1; s >= 0; s--) begin
      if (hit[s]) first_s = SWL'(s);
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    timeout_d   = timeout_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    if (realign) begin
      // Realign beats a simultaneous word; that word only refreshes prev.
      state_d   = ST_SEARCH;
      cnt_d     = '0;
      miss_d    = '0;
      timeout_d = 1'b0;
      if (in_valid) prev_d = in_data;
    end else if (in_valid) begin
      prev_d = in_data;
      unique case (state_q)
        ST_SEARCH: begin
          if (|hit) begin
            shift_d   = first_s;
            cnt_d     = 4'd1;
            state_d   = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
            miss_d    = '0;
            timeout_d = 1'b0;
          end else begin
            miss_d    = (miss_q == TO_MAX) ? miss_q : miss_q + 1'b1;
            timeout_d = timeout_q | (miss_d == TO_MAX);
          end
        end
        ST_VERIFY: begin
          if (cand_sel == MARKER) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LCNT) state_d = ST_LOCKED;
          end else begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end
        end
        ST_LOCKED: begin
          out_valid_d = 1'b1;
          out_data_d  = cand_sel;
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      prev_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      miss_q      <= '0;
      timeout_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      timeout_q   <= timeout_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign locked         = locked_q;
  assign shift          = shift_q;
  assign search_timeout = timeout_q;

endmodule
